ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. It is the transmit counterpart of the keyboard receive path (ps2_kbd_top) and lets the design send command bytes to the keyboard, for example 0xED (set LEDs) or 0xFF (reset).
- It drives the shared PS/2 clock and data lines through active-high open-drain pull-down enables.
- It runs on the 50 MHz keyboard clock domain.
- While busy it inhibits the bus, so the receive path sees no device frames.

---
 rtl/ps2_host_tx.sv | 209 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx
//  Brief    : PS/2 host-to-device transmitter. Inhibits the bus, issues a
//             request-to-send, then shifts a command byte, odd parity and
//             stop bit out on device-generated clocks and checks the ACK.
//             Lines are driven through active-high open-drain pull-downs.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       ps2clk_oe,
    output logic       ps2data_oe,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy
);

    localparam int FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int ICNT_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INHIBIT  = 3'd1,
        S_REQ      = 3'd2,
        S_START    = 3'd3,
        S_SHIFT    = 3'd4,
        S_WAIT_REL = 3'd5
    } state_t;

    logic [1:0]        clk_sync_q, clk_sync_d;
    logic [1:0]        data_sync_q, data_sync_d;
    logic              filt_clk_q, filt_clk_d;
    logic [FCNT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic              fall_q, fall_d;

    state_t            state_q, state_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              parity_q, parity_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [ICNT_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TCNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic              clk_oe_q, clk_oe_d;
    logic              data_oe_q, data_oe_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;

    // Synchronise both pins and debounce the clock; fall is a 1-cycle strobe
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2clk_in};
        data_sync_d = {data_sync_q[0], ps2data_in};
        filt_clk_d  = filt_clk_q;
        filt_cnt_d  = '0;
        if (clk_sync_q[1] != filt_clk_q) begin
            if (filt_cnt_q == FCNT_W'(FILTER_LEN - 1)) begin
                filt_clk_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + FCNT_W'(1);
            end
        end
        fall_d = filt_clk_q & ~filt_clk_d;
    end

    // Frame sequencing: next state, bit counter, timeouts and line drives
    always_comb begin
        state_d   = state_q;
        tx_byte_d = tx_byte_q;
        parity_d  = parity_q;
        bit_cnt_d = bit_cnt_q;
        inh_cnt_d = inh_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid && ready_q) begin
                    tx_byte_d = tx_data;
                    parity_d  = ~^tx_data;
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_cnt_q == ICNT_W'(INHIBIT_CYCLES - 1)) begin
                    data_oe_d = 1'b1;
                    state_d   = S_REQ;
                end else begin
                    inh_cnt_d = inh_cnt_q + ICNT_W'(1);
                end
            end
            S_REQ: begin
                clk_oe_d  = 1'b0;
                tmo_cnt_d = '0;
                state_d   = S_START;
            end
            S_START, S_SHIFT, S_WAIT_REL: begin
                tmo_cnt_d = tmo_cnt_q + TCNT_W'(1);
                if (fall_q) begin
                    // A device clock edge always beats a coincident timeout
                    tmo_cnt_d = '0;
                    if (state_q == S_START) begin
                        bit_cnt_d = 4'd1;
                        data_oe_d = ~tx_byte_q[0];
                        tx_byte_d = tx_byte_q >> 1;
                        state_d   = S_SHIFT;
                    end else if (state_q == S_SHIFT) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q < 4'd8) begin
                            data_oe_d = ~tx_byte_q[0];
                            tx_byte_d = tx_byte_q >> 1;
                        end else if (bit_cnt_q == 4'd8) begin
                            data_oe_d = ~parity_q;
                        end else if (bit_cnt_q == 4'd9) begin
                            data_oe_d = 1'b0;
                        end else if (!data_sync_q[1]) begin
                            state_d = S_WAIT_REL;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end else if (state_q == S_WAIT_REL && filt_clk_q && data_sync_q[1]) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (tmo_cnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Elapsed count reaches TIMEOUT_CYCLES in this cycle
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase

        // Ready only from the second IDLE cycle, so it follows the done/err pulse
        ready_d = (state_d == S_IDLE) && (state_q == S_IDLE);
    end

    // State and output registers; reset releases both lines immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_clk_q  <= 1'b1;
            filt_cnt_q  <= '0;
            fall_q      <= 1'b0;
            state_q     <= S_IDLE;
            tx_byte_q   <= '0;
            parity_q    <= 1'b0;
            bit_cnt_q   <= '0;
            inh_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_clk_q  <= filt_clk_d;
            filt_cnt_q  <= filt_cnt_d;
            fall_q      <= fall_d;
            state_q     <= state_d;
            tx_byte_q   <= tx_byte_d;
            parity_q    <= parity_d;
            bit_cnt_q   <= bit_cnt_d;
            inh_cnt_q   <= inh_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
        end
    end

    assign tx_ready   = ready_q;
    assign busy       = ~ready_q;
    assign ps2clk_oe  = clk_oe_q;
    assign ps2data_oe = data_oe_q;
    assign tx_done    = done_q;
    assign tx_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_host_tx
//  Brief    : Directed self-checking bench for ps2_host_tx with a PS/2
//             device model that clocks the frame and samples on rising edges.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2clk_in;
    logic       ps2data_in;
    logic       ps2clk_oe;
    logic       ps2data_oe;
    logic       tx_done;
    logic       tx_err;
    logic       busy;

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic glitch       = 1'b0;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    logic [10:0] frame_bits;
    bit          frame_ok;

    // Open-drain bus: any pull-down wins
    assign ps2clk_in  = ~(ps2clk_oe | dev_clk_low | glitch);
    assign ps2data_in = ~(ps2data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(20),
        .FILTER_LEN    (2),
        .TIMEOUT_CYCLES(400)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .ps2clk_in (ps2clk_in),
        .ps2data_in(ps2data_in),
        .ps2clk_oe (ps2clk_oe),
        .ps2data_oe(ps2data_oe),
        .tx_done   (tx_done),
        .tx_err    (tx_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
        if (tx_done && tx_err) both_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Checks the inhibit length, the single REQ cycle and the START drive
    task automatic check_request_phase();
        int n;
        n = 0;
        while (!ps2clk_oe && n < 10) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (ps2clk_oe && !ps2data_oe && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 20) begin
            errors++;
            $display("FAIL inhibit_len: got %0d cycles expected 20", n);
        end
        checks++;
        if ({ps2clk_oe, ps2data_oe} !== 2'b11) begin
            errors++;
            $display("FAIL req_cycle: got oe=%b expected 11", {ps2clk_oe, ps2data_oe});
        end
        @(negedge clk);
        checks++;
        if ({ps2clk_oe, ps2data_oe} !== 2'b01) begin
            errors++;
            $display("FAIL start_drive: got oe=%b expected 01", {ps2clk_oe, ps2data_oe});
        end
    endtask

    // Device: samples start, 10 clocked bits on rising edges, then ACK clock
    task automatic device_frame(input bit ack, input bit glitchy);
        int n;
        frame_bits = '0;
        frame_ok   = 1'b0;
        n = 0;
        while (!(!ps2clk_oe && ps2data_oe) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(!ps2clk_oe && ps2data_oe)) return;
        repeat (10) @(negedge clk);
        frame_bits[0] = ps2data_in;
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (10) @(negedge clk);
            dev_clk_low = 1'b0;
            frame_bits[i] = ps2data_in;
            if (glitchy) begin
                repeat (4) @(negedge clk);
                glitch = 1'b1;
                @(negedge clk);
                glitch = 1'b0;
                repeat (5) @(negedge clk);
            end else begin
                repeat (10) @(negedge clk);
            end
        end
        if (ack) dev_data_low = 1'b1;
        repeat (2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (10) @(negedge clk);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (10) @(negedge clk);
        frame_ok = 1'b1;
    endtask

    task automatic pulse_valid_while_busy();
        repeat (6) begin
            repeat (30) @(negedge clk);
            tx_data  = 8'h00;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({ps2clk_oe, ps2data_oe} !== 2'b00) begin
            errors++;
            $display("FAIL reset_oe: got %b expected 00", {ps2clk_oe, ps2data_oe});
        end
        checks++;
        if ({tx_done, tx_err} !== 2'b00) begin
            errors++;
            $display("FAIL reset_pulses: got %b expected 00", {tx_done, tx_err});
        end
        checks++;
        if ({tx_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_ready_busy: got %b expected 10", {tx_ready, busy});
        end
    endtask

    // Full frame: byte b with hand-computed parity par; ack selects done or err
    task automatic test_send(input logic [7:0] b, input logic par, input bit ack, input bit glitchy);
        int d0, e0, stray;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(b);
        fork
            check_request_phase();
            device_frame(ack, glitchy);
            begin
                if (glitchy) pulse_valid_while_busy();
            end
        join
        checks++;
        if (frame_ok !== 1'b1) begin
            errors++;
            $display("FAIL frame_seen[%h]: got %b expected 1", b, frame_ok);
        end
        checks++;
        if (frame_bits[0] !== 1'b0 || frame_bits[10] !== 1'b1) begin
            errors++;
            $display("FAIL start_stop[%h]: got start=%b stop=%b expected 0/1", b, frame_bits[0], frame_bits[10]);
        end
        checks++;
        if (frame_bits[8:1] !== b) begin
            errors++;
            $display("FAIL data_bits: got %h expected %h", frame_bits[8:1], b);
        end
        checks++;
        if (frame_bits[9] !== par) begin
            errors++;
            $display("FAIL parity[%h]: got %b expected %b", b, frame_bits[9], par);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== (ack ? 1 : 0)) begin
            errors++;
            $display("FAIL done_count[%h]: got %0d expected %0d", b, done_cnt - d0, ack ? 1 : 0);
        end
        checks++;
        if (err_cnt - e0 !== (ack ? 0 : 1)) begin
            errors++;
            $display("FAIL err_count[%h]: got %0d expected %0d", b, err_cnt - e0, ack ? 0 : 1);
        end
        checks++;
        if ({ps2clk_oe, ps2data_oe, tx_ready, busy} !== 4'b0010) begin
            errors++;
            $display("FAIL idle_after[%h]: got oe/ready/busy=%b expected 0010",
                     b, {ps2clk_oe, ps2data_oe, tx_ready, busy});
        end
        checks++;
        if (both_cnt !== 0) begin
            errors++;
            $display("FAIL done_and_err: got %0d overlaps expected 0", both_cnt);
        end
        if (glitchy) begin
            stray = 0;
            repeat (100) begin
                @(negedge clk);
                if (ps2clk_oe) stray++;
            end
            checks++;
            if (stray !== 0) begin
                errors++;
                $display("FAIL no_queued_request: got %0d busy cycles expected 0", stray);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        send_byte(8'h55);
        n = 0;
        while (!ps2clk_oe && n < 10) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (ps2clk_oe && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!tx_err && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 400) begin
            errors++;
            $display("FAIL timeout_len: got %0d cycles expected 400", n);
        end
        checks++;
        if ({ps2clk_oe, ps2data_oe} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_release: got %b expected 00", {ps2clk_oe, ps2data_oe});
        end
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_ready: got %b expected 1", tx_ready);
        end
    endtask

    task automatic test_async_reset();
        int n;
        send_byte(8'hED);
        n = 0;
        while (!(!ps2clk_oe && ps2data_oe) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            dev_clk_low = 1'b1;
            repeat (10) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (10) @(negedge clk);
        end
        dev_clk_low = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if ({ps2clk_oe, ps2data_oe} !== 2'b01) begin
            errors++;
            $display("FAIL bit4_drive: got %b expected 01", {ps2clk_oe, ps2data_oe});
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({ps2clk_oe, ps2data_oe} !== 2'b00) begin
            errors++;
            $display("FAIL async_reset_oe: got %b expected 00", {ps2clk_oe, ps2data_oe});
        end
        checks++;
        if ({tx_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL async_reset_ready: got %b expected 10", {tx_ready, busy});
        end
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        test_send(8'hED, 1'b1, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        test_send(8'h01, 1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        test_send(8'hFF, 1'b1, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        test_send(8'hED, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        test_timeout();
        repeat (10) @(negedge clk);
        test_async_reset();
        test_send(8'hED, 1'b1, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        test_send(8'hED, 1'b1, 1'b1, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
